req_encoder: RTL and testbench

Sequential 4-to-2 request encoder with handshake; the inverse of the team's 2-to-4 enable decoder (`dc`). It captures request lines into a sticky pending mask and selects one pending request by fixed or round-robin priority. It presents the 2-bit index with a valid flag and holds it until the consumer accepts. It sits between request-generating logic and any block that consumes a binary index, for example a `dc` instance driving one-hot selects.

---
 rtl/req_encoder_if.sv | 21 ++
 rtl/req_encoder.sv | 108 ++++++++++
 tb/tb_req_encoder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/req_encoder_if.sv
// Request/grant bundle between request-generating logic and the req_encoder.
// The master drives requests, the enable and ready; the slave returns the encoded grant.
interface req_encoder_if;
  logic [3:0] ireq;
  logic       ien;
  logic       iready;
  logic [1:0] oidx;
  logic       ovalid;
  logic       omulti;
  logic [3:0] opend;

  modport master (
    output ireq, ien, iready,
    input  oidx, ovalid, omulti, opend
  );

  modport slave (
    input  ireq, ien, iready,
    output oidx, ovalid, omulti, opend
  );
endinterface

// File: rtl/req_encoder.sv
// Sequential 4-to-2 request encoder: sticky pending mask, fixed or rotating
// priority selection, and a valid/ready hold of the chosen index.
module req_encoder #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic         iclk,
  input  logic         irst,
  req_encoder_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_reg;
  logic [3:0] pend_reg;
  logic [3:0] pend_next;
  logic [1:0] ptr_reg;
  logic [1:0] oidx_reg;
  logic       ovalid_reg;
  logic       omulti_reg;

  logic       accept;
  logic [3:0] clr;
  logic [3:0] rot;
  logic [1:0] off;
  logic [1:0] sel_idx;
  logic [2:0] pend_cnt;
  logic       multi;

  assign accept = ovalid_reg & bus.iready;

  // rot[k] is the pending bit k places after ptr, so the lowest set bit of
  // rot is the first candidate in rotating order.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bits
      assign clr[gi] = accept && (oidx_reg == 2'(gi));
      assign rot[gi] = pend_reg[2'(gi) + ptr_reg];
    end
  endgenerate

  // Set wins over clear: a request on the served bit in the accept cycle stays.
  assign pend_next = (pend_reg & ~clr) | (bus.ien ? bus.ireq : 4'b0000);

  always_comb begin
    off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) begin
        off = 2'(i);
      end
    end
  end

  always_comb begin
    pend_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      pend_cnt = pend_cnt + {2'b00, pend_reg[i]};
    end
  end

  assign sel_idx = ptr_reg + off;
  assign multi   = (pend_cnt >= 3'd2);

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_reg  <= IDLE;
      pend_reg   <= 4'b0000;
      ptr_reg    <= 2'd0;
      oidx_reg   <= 2'd0;
      ovalid_reg <= 1'b0;
      omulti_reg <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      case (state_reg)
        IDLE: begin
          // Selection looks only at the registered mask, never same-cycle ireq.
          if (pend_reg != 4'b0000) begin
            oidx_reg   <= sel_idx;
            omulti_reg <= multi;
            ovalid_reg <= 1'b1;
            state_reg  <= GRANT;
          end
        end
        GRANT: begin
          if (bus.iready) begin
            ovalid_reg <= 1'b0;
            state_reg  <= IDLE;
            if (ROUND_ROBIN) begin
              ptr_reg <= oidx_reg + 2'd1;
            end
          end
        end
        default: begin
          state_reg  <= IDLE;
          ovalid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oidx   = oidx_reg;
  assign bus.ovalid = ovalid_reg;
  assign bus.omulti = omulti_reg;
  assign bus.opend  = pend_reg;

endmodule

// File: tb/tb_req_encoder.sv
// Directed bench for req_encoder: one fixed-priority and one round-robin
// instance, expected values worked out by hand from the behaviour description.
module tb_req_encoder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  req_encoder_if fix_if ();
  req_encoder_if rr_if ();

  req_encoder #(.ROUND_ROBIN(1'b0)) u_fix (
    .iclk (clk),
    .irst (rst),
    .bus  (fix_if)
  );

  req_encoder #(.ROUND_ROBIN(1'b1)) u_rr (
    .iclk (clk),
    .irst (rst),
    .bus  (rr_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fix_if.ireq = 4'b0000; fix_if.ien = 1'b1; fix_if.iready = 1'b0;
    rr_if.ireq  = 4'b0000; rr_if.ien  = 1'b1; rr_if.iready  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int exp_idx;
  int grants;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle_inputs();
    do_reset();

    // Reset values
    check("rst_fix_out", {fix_if.opend, fix_if.oidx, fix_if.ovalid, fix_if.omulti}, 8'h00);
    check("rst_rr_out",  {rr_if.opend, rr_if.oidx, rr_if.ovalid, rr_if.omulti}, 8'h00);

    // Async reset mid-grant with pend = 1011
    rr_if.ireq = 4'b1011;
    tick();
    rr_if.ireq = 4'b0000;
    check("midrst_pend", {4'h0, rr_if.opend}, 8'h0b);
    tick();
    check("midrst_grant", {5'b0, rr_if.oidx, rr_if.ovalid}, {5'b0, 2'd0, 1'b1});
    #2;
    rst = 1'b1;
    #1;
    check("midrst_async", {rr_if.opend, rr_if.oidx, rr_if.ovalid, rr_if.omulti}, 8'h00);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_noval", {7'b0, rr_if.ovalid}, 8'h00);
    end

    // Single request, fixed mode
    do_reset();
    fix_if.ireq = 4'b0100; fix_if.iready = 1'b1;
    tick();
    fix_if.ireq = 4'b0000;
    check("single_pend", {3'b0, fix_if.opend, fix_if.ovalid}, {3'b0, 4'b0100, 1'b0});
    tick();
    check("single_grant", {4'b0, fix_if.oidx, fix_if.ovalid, fix_if.omulti}, {4'b0, 2'd2, 1'b1, 1'b0});
    tick();
    check("single_done", {3'b0, fix_if.opend, fix_if.ovalid}, 8'h00);

    // Fixed priority
    do_reset();
    fix_if.ireq = 4'b1010; fix_if.iready = 1'b1;
    tick();
    fix_if.ireq = 4'b0000;
    check("fixpri_pend", {4'h0, fix_if.opend}, 8'h0a);
    tick();
    check("fixpri_g1", {4'b0, fix_if.oidx, fix_if.ovalid, fix_if.omulti}, {4'b0, 2'd1, 1'b1, 1'b1});
    tick();
    check("fixpri_acc1", {3'b0, fix_if.opend, fix_if.ovalid}, {3'b0, 4'b1000, 1'b0});
    tick();
    check("fixpri_g2", {4'b0, fix_if.oidx, fix_if.ovalid, fix_if.omulti}, {4'b0, 2'd3, 1'b1, 1'b0});
    tick();
    check("fixpri_done", {3'b0, fix_if.opend, fix_if.ovalid}, 8'h00);

    // Round-robin wrap: grants on every second edge, index rotating 0..3
    do_reset();
    rr_if.ireq = 4'b1111; rr_if.iready = 1'b1;
    exp_idx = 0;
    grants  = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("rr_valid", {7'b0, rr_if.ovalid}, {7'b0, 1'((c % 2) == 1)});
      if (rr_if.ovalid) begin
        check("rr_idx", {6'b0, rr_if.oidx}, 8'(exp_idx));
        check("rr_multi", {7'b0, rr_if.omulti}, 8'h01);
        exp_idx = (exp_idx + 1) % 4;
        grants++;
      end
    end
    check("rr_grants", 8'(grants), 8'd10);
    rr_if.ireq = 4'b0000; rr_if.iready = 1'b0;

    // Backpressure
    do_reset();
    rr_if.ireq = 4'b0001;
    tick();
    rr_if.ireq = 4'b0000;
    tick();
    check("bp_grant", {5'b0, rr_if.oidx, rr_if.ovalid}, {5'b0, 2'd0, 1'b1});
    for (int c = 0; c < 5; c++) begin
      rr_if.ireq = (c % 2 == 0) ? 4'b0010 : 4'b0000;
      tick();
      check("bp_hold", {5'b0, rr_if.oidx, rr_if.ovalid}, {5'b0, 2'd0, 1'b1});
    end
    rr_if.ireq = 4'b0000;
    check("bp_pend", {4'h0, rr_if.opend}, 8'h03);
    rr_if.iready = 1'b1;
    tick();
    check("bp_acc", {3'b0, rr_if.opend, rr_if.ovalid}, {3'b0, 4'b0010, 1'b0});
    tick();
    check("bp_next", {4'b0, rr_if.oidx, rr_if.ovalid, rr_if.omulti}, {4'b0, 2'd1, 1'b1, 1'b0});

    // Enable gating
    do_reset();
    fix_if.ireq = 4'b0001;
    tick();
    fix_if.ien = 1'b0; fix_if.ireq = 4'b1000;
    tick();
    check("en_off_pend", {3'b0, fix_if.opend, fix_if.ovalid}, {3'b0, 4'b0001, 1'b1});
    tick();
    check("en_off_hold", {4'h0, fix_if.opend}, 8'h01);
    fix_if.ien = 1'b1; fix_if.ireq = 4'b0000;

    // Set over clear on the served bit
    do_reset();
    fix_if.ireq = 4'b1000;
    tick();
    tick();
    check("soc_grant", {5'b0, fix_if.oidx, fix_if.ovalid}, {5'b0, 2'd3, 1'b1});
    fix_if.iready = 1'b1;
    tick();
    fix_if.ireq = 4'b0000;
    check("soc_acc", {3'b0, fix_if.opend, fix_if.ovalid}, {3'b0, 4'b1000, 1'b0});
    tick();
    check("soc_regrant", {5'b0, fix_if.oidx, fix_if.ovalid}, {5'b0, 2'd3, 1'b1});
    tick();
    check("soc_done", {3'b0, fix_if.opend, fix_if.ovalid}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
